adc_sample_averager: RTL and testbench

ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

---
 rtl/adc_sample_averager.sv | 141 ++++++++++++++
 tb/tb_adc_sample_averager.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_averager.sv
// Periodically triggers an ADC conversion, reads the result over DRP and emits
// the truncated mean of every 2^AVG_LOG2 samples; a sticky flag records lost handshakes.
module adc_sample_averager #(
  parameter int unsigned SAMPLE_PERIOD = 1000,
  parameter int unsigned AVG_LOG2      = 4,
  parameter logic [6:0]  DRP_ADDR      = 7'h13,
  parameter int unsigned TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        reset,
  output logic        convst,
  input  logic        eoc,
  output logic        den,
  output logic [6:0]  daddr,
  input  logic        drdy,
  input  logic [15:0] drp_do,
  output logic [15:0] adc_data,
  output logic        adc_valid,
  output logic        timeout_err
);

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ACC_W   = DATA_W + AVG_LOG2;
  localparam int unsigned CNT_W   = AVG_LOG2 + 1;
  localparam int unsigned TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned WAIT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    READ     = 3'd2,
    WAIT_RDY = 3'd3,
    ACCUM    = 3'd4
  } state_t;

  state_t              state;
  logic [TIMER_W-1:0]  timer;
  logic                tick;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]   sample;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt;
  logic [ACC_W-1:0]    sum_c;

  assign daddr = DRP_ADDR;

  // Accumulator is wide enough for 2^AVG_LOG2 full-scale samples, so no wrap.
  assign sum_c = acc + ACC_W'(sample);

  // Free-running sample timer; tick is high on the cycle the timer reads 0 after a wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (timer == TIMER_LAST);
      timer <= (timer == TIMER_LAST) ? '0 : timer + TIMER_W'(1);
    end
  end

  // Conversion / DRP read / accumulate sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      sample      <= '0;
      acc         <= '0;
      cnt         <= '0;
      adc_data    <= '0;
      adc_valid   <= 1'b0;
      convst      <= 1'b0;
      den         <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      convst    <= 1'b0;
      den       <= 1'b0;
      adc_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (tick) begin
            state    <= CONV;
            convst   <= 1'b1;
            wait_cnt <= '0;
          end
        end

        // eoc is honoured from the very first CONV cycle, alongside convst.
        CONV: begin
          if (eoc) begin
            state <= READ;
            den   <= 1'b1;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        READ: begin
          state    <= WAIT_RDY;
          wait_cnt <= '0;
        end

        WAIT_RDY: begin
          if (drdy) begin
            sample <= drp_do;
            state  <= ACCUM;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= IDLE;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end

        // Last sample of the block publishes the mean and restarts the block.
        ACCUM: begin
          state <= IDLE;
          if (cnt == CNT_LAST) begin
            adc_data  <= DATA_W'(sum_c >> AVG_LOG2);
            adc_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
          end else begin
            acc <= sum_c;
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: behavioural ADC/DRP responder plus a block-mean
// reference computed from the samples actually handed to the design.
module tb_adc_sample_averager;

  localparam int unsigned SP   = 20;
  localparam int unsigned LOG2 = 4;
  localparam int unsigned N    = 16;
  localparam int unsigned TO   = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        convst;
  logic        eoc;
  logic        den;
  logic [6:0]  daddr;
  logic        drdy;
  logic [15:0] drp_do;
  logic [15:0] adc_data;
  logic        adc_valid;
  logic        timeout_err;

  adc_sample_averager #(
    .SAMPLE_PERIOD(SP),
    .AVG_LOG2(LOG2),
    .DRP_ADDR(7'h13),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .convst(convst),
    .eoc(eoc),
    .den(den),
    .daddr(daddr),
    .drdy(drdy),
    .drp_do(drp_do),
    .adc_data(adc_data),
    .adc_valid(adc_valid),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Responder configuration and bookkeeping
  bit          eoc_en       = 1'b1;
  int          eoc_delay    = 3;
  int          drdy_delay   = 2;
  bit          drop_pending = 1'b0;
  int          eoc_cnt      = 0;
  int          drdy_cnt     = 0;
  logic [15:0] data_q[$];
  logic [15:0] delivered[$];

  // Monitor counters
  int cyc             = 0;
  int n_convst        = 0;
  int n_den           = 0;
  int n_overlap       = 0;
  int n_valid_long    = 0;
  int last_convst_cyc = 0;
  bit valid_prev      = 1'b0;

  logic [15:0] last_avg = 16'h0000;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ADC and DRP model: eoc eoc_delay cycles after convst, drdy drdy_delay cycles after den.
  initial begin
    eoc    = 1'b0;
    drdy   = 1'b0;
    drp_do = 16'h0000;
    forever begin
      @(negedge clk);
      eoc  = 1'b0;
      drdy = 1'b0;
      if (eoc_cnt > 0) begin
        eoc_cnt--;
        if (eoc_cnt == 0) eoc = 1'b1;
      end
      if (convst && eoc_en) begin
        if (eoc_delay == 0) eoc = 1'b1;
        else eoc_cnt = eoc_delay;
      end
      if (drdy_cnt > 0) begin
        drdy_cnt--;
        if (drdy_cnt == 0) begin
          drdy = 1'b1;
          if (drop_pending) begin
            drop_pending = 1'b0;
            drp_do = 16'($urandom);
          end else begin
            drp_do = (data_q.size() > 0) ? data_q.pop_front() : 16'($urandom);
            delivered.push_back(drp_do);
          end
        end
      end
      if (den) drdy_cnt = drdy_delay;
    end
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (convst) begin
      n_convst++;
      last_convst_cyc = cyc;
    end
    if (den) n_den++;
    if (den && convst) n_overlap++;
    if (adc_valid && valid_prev) n_valid_long++;
    valid_prev = adc_valid;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_convst(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (convst) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_den(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (den) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (adc_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_err(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (timeout_err) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_delivered(input int count, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (delivered.size() >= count) begin ok = 1'b1; break; end
    end
  endtask

  // Wait for a strobe, then compare against the mean of the N samples delivered.
  task automatic check_window(input string tag, input int budget);
    bit ok;
    int sum;
    wait_valid(budget, ok);
    check({tag, "_valid_seen"}, 32'(ok), 32'd1);
    if (ok) begin
      check({tag, "_samples"}, 32'(delivered.size()), 32'(N));
      sum = 0;
      repeat (N) if (delivered.size() > 0) sum += int'(delivered.pop_front());
      last_avg = 16'(sum / N);
      check({tag, "_data"}, 32'(adc_data), 32'(last_avg));
      @(negedge clk);
      check({tag, "_strobe_width"}, 32'(adc_valid), 32'd0);
      check({tag, "_hold"}, 32'(adc_data), 32'(last_avg));
    end
  endtask

  task automatic push_random(input int count);
    repeat (count) data_q.push_back(16'($urandom));
  endtask

  initial begin
    bit ok;
    int rel_cyc;
    int t0;
    int v1;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_convst", 32'(convst), 32'd0);
    check("rst_den", 32'(den), 32'd0);
    check("rst_valid", 32'(adc_valid), 32'd0);
    check("rst_data", 32'(adc_data), 32'd0);
    check("rst_err", 32'(timeout_err), 32'd0);
    check("daddr", 32'(daddr), 32'h13);

    // Constant mid-scale input, tick timing and output period
    repeat (2 * N) data_q.push_back(16'h8000);
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_convst(SP + 5, ok);
    check("first_convst_seen", 32'(ok), 32'd1);
    check("first_convst_cycle", 32'(cyc - rel_cyc), 32'(SP + 1));
    t0 = cyc;
    wait_convst(SP + 5, ok);
    check("convst_period", 32'(cyc - t0), 32'(SP));
    check_window("const1", 3 * N * SP);
    check("const1_value", 32'(adc_data), 32'h8000);
    v1 = cyc;
    check_window("const2", 3 * N * SP);
    check("valid_period", 32'(cyc - v1), 32'(N * SP));

    // Ramp 0..15 and full-scale blocks
    for (int i = 0; i < 16; i++) data_q.push_back(16'(i));
    check_window("ramp", 3 * N * SP);
    check("ramp_value", 32'(adc_data), 32'h0007);
    repeat (N) data_q.push_back(16'hFFFF);
    check_window("fullscale", 3 * N * SP);
    check("fullscale_value", 32'(adc_data), 32'hFFFF);

    // Random data, eoc coincident with convst, then other latencies
    eoc_delay = 0;
    push_random(N);
    check_window("rand_eoc0", 3 * N * SP);
    eoc_delay  = 5;
    drdy_delay = 7;
    push_random(N);
    check_window("rand_lat", 3 * N * SP);

    // Read slower than the tick period: in-between ticks must be dropped
    eoc_delay  = 3;
    drdy_delay = SP + 10;
    n_convst   = 0;
    n_den      = 0;
    push_random(N);
    repeat (100) @(negedge clk);
    check("hold_mid_window", 32'(adc_data), 32'(last_avg));
    check_window("slow_read", 6 * N * SP);
    check("slow_convst_count", 32'(n_convst), 32'(N));
    check("slow_den_count", 32'(n_den), 32'(N));

    // Withheld eoc mid-block: timeout, then the block resumes where it stopped
    drdy_delay = 2;
    push_random(N);
    wait_delivered(5, 8 * SP, ok);
    check("to_pre_samples", 32'(ok), 32'd1);
    eoc_en   = 1'b0;
    n_convst = 0;
    wait_err(TO + 4 * SP, ok);
    check("to_err_seen", 32'(ok), 32'd1);
    check("to_span", 32'(cyc - last_convst_cyc), 32'(TO));
    check("to_single_convst", 32'(n_convst), 32'd1);
    eoc_en = 1'b1;
    wait_convst(SP + 2, ok);
    check("to_restart_convst", 32'(ok), 32'd1);
    check_window("after_timeout", 3 * N * SP);
    check("err_sticky", 32'(timeout_err), 32'd1);

    // Reset during WAIT_RDY with half a block accumulated
    drdy_delay = 10;
    push_random(N);
    wait_delivered(8, 12 * SP, ok);
    check("rst_pre_samples", 32'(ok), 32'd1);
    wait_den(3 * SP, ok);
    check("rst_den_seen", 32'(ok), 32'd1);
    repeat (2) @(negedge clk);
    reset        = 1'b1;
    drop_pending = 1'b1;
    @(negedge clk);
    check("mid_rst_data", 32'(adc_data), 32'd0);
    check("mid_rst_err", 32'(timeout_err), 32'd0);
    check("mid_rst_valid", 32'(adc_valid), 32'd0);
    check("mid_rst_den", 32'(den), 32'd0);
    check("mid_rst_convst", 32'(convst), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    rel_cyc = cyc;
    delivered.delete();
    data_q.delete();
    push_random(N);
    wait_convst(SP + 5, ok);
    check("post_rst_convst_cycle", 32'(cyc - rel_cyc), 32'(SP + 1));
    check_window("post_reset", 4 * N * SP);

    check("den_convst_overlap", 32'(n_overlap), 32'd0);
    check("valid_multi_cycle", 32'(n_valid_long), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
